reduce_tree_pipe: RTL and testbench

Parametrised, pipelined N-input logic reduction tree: the next generation of the team's four-input AND block (two pairwise ANDs feeding a final AND). It generalises the input count to any power of two, adds a per-transaction reduction mode (AND/OR/XOR/NAND), and registers every tree level. A valid/ready handshake with back-pressure lets it sit between a stimulus source and a result consumer in the lab test fabric. Intermediate half-results are exported so benches can check the internal pair values as before.

---
 rtl/reduce_tree_pipe.sv | 109 ++++++++++
 tb/tb_reduce_tree_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_tree_pipe.sv
`timescale 1ns/1ps
// Pipelined N-input AND/OR/XOR/NAND reduction tree with one register level per tree level
// and a global-enable valid/ready handshake.
module reduce_tree_pipe #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [1:0]       out_half,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned LOG2N = $clog2(N);

  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  // All tree levels packed into one vector: level k (width N>>k) sits at offset N-2*(N>>k).
  logic [N-2:0]            tree_nxt;
  logic [N-2:0]            tree_q;
  logic [LOG2N:1]          valid_q;
  logic [LOG2N:1][1:0]     mode_q;
  logic [1:0]              half_src;
  logic [1:0]              half_q;
  logic [CNT_W-1:0]        count_q;
  logic                    stall;

  function automatic logic pair_op(input logic [1:0] mode, input logic a, input logic b);
    case (mode)
      MODE_OR:  return a | b;
      MODE_XOR: return a ^ b;
      default:  return a & b;
    endcase
  endfunction

  assign stall    = valid_q[LOG2N] && !out_ready;
  assign in_ready = !stall;

  // Combinational next value of every level; only the final bit is inverted for NAND.
  for (genvar k = 1; k <= LOG2N; k++) begin : g_level
    localparam int unsigned SW  = N >> k;
    localparam int unsigned OFF = N - 2 * SW;

    logic [2*SW-1:0] src;
    logic [1:0]      src_mode;

    if (k == 1) begin : g_from_in
      assign src      = in_data;
      assign src_mode = in_mode;
    end else begin : g_from_prev
      assign src      = tree_q[N-2*SW-1 : N-4*SW];
      assign src_mode = mode_q[k-1];
    end

    for (genvar i = 0; i < SW; i++) begin : g_bit
      if (k == LOG2N) begin : g_final
        assign tree_nxt[OFF+i] = pair_op(src_mode, src[2*i+1], src[2*i]) ^ (src_mode == MODE_NAND);
      end else begin : g_inner
        assign tree_nxt[OFF+i] = pair_op(src_mode, src[2*i+1], src[2*i]);
      end
    end

    if (k == LOG2N) begin : g_half
      assign half_src = src;
    end
  end

  // Every stage advances together unless the result at the output is being held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q  <= '0;
      valid_q <= '0;
      mode_q  <= '0;
      half_q  <= '0;
      count_q <= '0;
    end else begin
      if (!stall) begin
        tree_q     <= tree_nxt;
        half_q     <= half_src;
        valid_q[1] <= in_valid;
        mode_q[1]  <= in_mode;
        for (int k = 2; k <= int'(LOG2N); k++) begin
          valid_q[k] <= valid_q[k-1];
          mode_q[k]  <= mode_q[k-1];
        end
      end
      if (valid_q[LOG2N] && out_ready) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = valid_q[LOG2N];
  assign out_data  = tree_q[N-2];
  assign out_half  = half_q;
  assign out_mode  = mode_q[LOG2N];
  assign out_count = count_q;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
`timescale 1ns/1ps
// Directed bench for reduce_tree_pipe: N=4, N=8, N=2 and a narrow-counter N=4 build.
module tb_reduce_tree_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // N=4, CNT_W=16
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_data;
  logic [3:0] a_in_data;
  logic [1:0] a_in_mode, a_out_half, a_out_mode;
  logic [15:0] a_out_count;
  // N=8
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_data;
  logic [7:0] b_in_data;
  logic [1:0] b_in_mode, b_out_half, b_out_mode;
  logic [15:0] b_out_count;
  // N=2
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_data;
  logic [1:0] c_in_data;
  logic [1:0] c_in_mode, c_out_half, c_out_mode;
  logic [15:0] c_out_count;
  // N=4, CNT_W=4
  logic w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_data;
  logic [3:0] w_in_data;
  logic [1:0] w_in_mode, w_out_half, w_out_mode;
  logic [3:0] w_out_count;

  reduce_tree_pipe #(.N(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_half(a_out_half), .out_mode(a_out_mode), .out_count(a_out_count));

  reduce_tree_pipe #(.N(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_half(b_out_half), .out_mode(b_out_mode), .out_count(b_out_count));

  reduce_tree_pipe #(.N(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_mode(c_in_mode), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_half(c_out_half), .out_mode(c_out_mode), .out_count(c_out_count));

  reduce_tree_pipe #(.N(4), .CNT_W(4)) dutw (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_mode(w_in_mode), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_half(w_out_half), .out_mode(w_out_mode), .out_count(w_out_count));

  function automatic logic ref_red(input logic [1:0] m, input logic [3:0] d);
    case (m)
      2'b00:   return &d;
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return ~(&d);
    endcase
  endfunction

  function automatic logic [1:0] ref_half(input logic [1:0] m, input logic [3:0] d);
    case (m)
      2'b01:   return {d[3] | d[2], d[1] | d[0]};
      2'b10:   return {d[3] ^ d[2], d[1] ^ d[0]};
      default: return {d[3] & d[2], d[1] & d[0]};
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    n_checks++;
    if (a_out_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_out_count); end
    n_checks++;
    if ({a_out_data, a_out_half, a_out_mode} !== 5'd0) begin
      n_fail++; $display("FAIL reset_payload: got %b want 00000", {a_out_data, a_out_half, a_out_mode});
    end
    n_checks++;
    if ({b_out_valid, c_out_valid, w_out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_other_valid: got %b want 000", {b_out_valid, c_out_valid, w_out_valid});
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_basic_and();
    do_reset();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_mode = 2'b00; a_in_data = 4'b1111;
    @(negedge clk); next_cycle();
    a_in_data = 4'b1011;
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: out_valid=%0b want 0", a_out_valid); end
    next_cycle();
    a_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_half} !== 4'b1111) begin
      n_fail++; $display("FAIL basic_first: valid/data/half=%b want 1111", {a_out_valid, a_out_data, a_out_half});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_half} !== 4'b1001) begin
      n_fail++; $display("FAIL basic_second: valid/data/half=%b want 1001", {a_out_valid, a_out_data, a_out_half});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: out_valid=%0b want 0", a_out_valid); end
    next_cycle();
  endtask

  task automatic test_all_modes();
    logic [1:0] m;
    logic [3:0] d;
    do_reset();
    a_out_ready = 1'b1;
    for (int c = 0; c <= 66; c++) begin
      if (c < 64) begin
        a_in_valid = 1'b1; a_in_mode = 2'(c / 16); a_in_data = 4'(c % 16);
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 2 && c < 66) begin
        m = 2'((c - 2) / 16);
        d = 4'((c - 2) % 16);
        n_checks++;
        if ({a_out_valid, a_out_data, a_out_half, a_out_mode} !== {1'b1, ref_red(m, d), ref_half(m, d), m}) begin
          n_fail++;
          $display("FAIL all_modes[m=%0d d=%h]: valid/data/half/mode=%b want %b", m, d,
                   {a_out_valid, a_out_data, a_out_half, a_out_mode}, {1'b1, ref_red(m, d), ref_half(m, d), m});
        end
      end
      if (c == 66) begin
        n_checks++;
        if (a_out_count !== 16'd64 || a_out_valid !== 1'b0) begin
          n_fail++; $display("FAIL all_modes_count: count=%0d valid=%0b want 64 0", a_out_count, a_out_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] bp_d [8];
    logic [1:0] bp_m [8];
    int ii;
    int oi;
    logic acc;
    bp_d = '{4'hF, 4'h0, 4'h7, 4'hF, 4'h8, 4'hE, 4'h1, 4'h0};
    bp_m = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    ii = 0;
    oi = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      a_out_ready = !(c >= 4 && c <= 8);
      a_in_valid  = (ii < 8);
      a_in_data   = (ii < 8) ? bp_d[ii] : 4'h0;
      a_in_mode   = (ii < 8) ? bp_m[ii] : 2'b00;
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if ({a_in_ready, a_out_valid} !== 2'b01) begin
          n_fail++; $display("FAIL bp_stall[c=%0d]: in_ready/out_valid=%b want 01", c, {a_in_ready, a_out_valid});
        end
      end
      if (a_out_valid) begin
        n_checks++;
        if (oi >= 8) begin
          n_fail++; $display("FAIL bp_extra: result %0d seen, only 8 sent", oi);
        end else if ({a_out_data, a_out_half, a_out_mode} !==
                     {ref_red(bp_m[oi], bp_d[oi]), ref_half(bp_m[oi], bp_d[oi]), bp_m[oi]}) begin
          n_fail++;
          $display("FAIL bp_result[%0d c=%0d]: data/half/mode=%b want %b", oi, c, {a_out_data, a_out_half, a_out_mode},
                   {ref_red(bp_m[oi], bp_d[oi]), ref_half(bp_m[oi], bp_d[oi]), bp_m[oi]});
        end
        if (a_out_ready) oi++;
      end
      if (acc) ii++;
      next_cycle();
    end
    a_in_valid = 1'b0;
    n_checks++;
    if (oi != 8 || a_out_count !== 16'd8) begin
      n_fail++; $display("FAIL bp_all_out: results=%0d count=%0d want 8 8", oi, a_out_count);
    end
  endtask

  task automatic test_wide_narrow();
    do_reset();
    b_out_ready = 1'b1; c_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_mode = 2'b10; b_in_data = 8'hA5;
    c_in_valid = 1'b1; c_in_mode = 2'b10; c_in_data = 2'b10;
    @(negedge clk); next_cycle();
    b_in_data = 8'h07;
    c_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({c_out_valid, c_out_data, c_out_half, c_out_mode} !== 6'b111010) begin
      n_fail++; $display("FAIL n2_xor: valid/data/half/mode=%b want 111010", {c_out_valid, c_out_data, c_out_half, c_out_mode});
    end
    n_checks++;
    if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL n8_early1: out_valid=%0b want 0", b_out_valid); end
    next_cycle();
    b_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b_out_valid, c_out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL n8_early2: b/c out_valid=%b want 00", {b_out_valid, c_out_valid});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({b_out_valid, b_out_data, b_out_half} !== 4'b1000) begin
      n_fail++; $display("FAIL n8_xor_a5: valid/data/half=%b want 1000", {b_out_valid, b_out_data, b_out_half});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({b_out_valid, b_out_data, b_out_half} !== 4'b1101) begin
      n_fail++; $display("FAIL n8_xor_07: valid/data/half=%b want 1101", {b_out_valid, b_out_data, b_out_half});
    end
    next_cycle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_mode = 2'b00; a_in_data = 4'hF;
    @(negedge clk); next_cycle();
    a_in_mode = 2'b01; a_in_data = 4'h1;
    @(negedge clk); next_cycle();
    a_in_mode = 2'b10; a_in_data = 4'h1;
    @(negedge clk); next_cycle();
    a_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_count} !== {1'b1, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL midrst_pre: valid=%0b data=%0b count=%0d want 1 1 1", a_out_valid, a_out_data, a_out_count);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_data, a_out_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL midrst_async: valid=%0b in_ready=%0b data=%0b count=%0d want 0 1 0 0",
                         a_out_valid, a_in_ready, a_out_data, a_out_count);
    end
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b0 || a_out_count !== 16'd0) begin
        n_fail++; $display("FAIL midrst_stale[c=%0d]: valid=%0b count=%0d want 0 0", c, a_out_valid, a_out_count);
      end
      next_cycle();
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    w_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      w_in_valid = (c < 17); w_in_mode = 2'b00; w_in_data = 4'hF;
      @(negedge clk);
      if (c == 10) begin
        n_checks++;
        if (w_out_count !== 4'd8) begin n_fail++; $display("FAIL wrap_mid: count=%0d want 8", w_out_count); end
      end
      if (c == 18) begin
        n_checks++;
        if (w_out_count !== 4'd0) begin n_fail++; $display("FAIL wrap_16: count=%0d want 0", w_out_count); end
      end
      if (c == 19) begin
        n_checks++;
        if (w_out_count !== 4'd1) begin n_fail++; $display("FAIL wrap_17: count=%0d want 1", w_out_count); end
      end
      next_cycle();
    end
    w_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_mode = '0; c_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_mode = '0; w_out_ready = 1'b1;
    #1;
    test_reset();
    test_basic_and();
    test_all_modes();
    test_backpressure();
    test_wide_narrow();
    test_reset_midstream();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
